md_unit_pipe: RTL and testbench
===============================

Name: md_unit_pipe

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers in the EX stage.
- Driven by the decoder's mdStart, mord, signmd, weMD, wHiLo and rHiLo outputs.
- Generalises the fixed 32-bit mult/div with configurable width and per-op latency.
- Adds a cancel input so an in-flight op can be aborted on a pipeline flush (exception/branch kill) without corrupting HI/LO.

Parameters:
WIDTH, 32, operand and HI/LO width
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin op this cycle (mdStart)
mord  in  1  0=multiply, 1=divide
signmd  in  1  1=signed operands, 0=unsigned
weMD  in  1  write HI or LO from A (mthi/mtlo)
wHiLo  in  1  write target: 0=HI, 1=LO
rHiLo  in  1  read select: 0=HI, 1=LO
cancel  in  1  abort in-flight op / drop same-cycle start or weMD
A  in  WIDTH  rs operand (dividend / multiplicand / mt source)
B  in  WIDTH  rt operand (divisor / multiplier)
busy  out  1  op in flight
rdata  out  WIDTH  HI or LO per rHiLo (mfhi/mflo data)

Behaviour:
- Reset (async, any time, including mid-op): HI=0, LO=0, state=IDLE, counter=0, busy=0, latched operands=0. No partial result is committed.
- States: IDLE, MULT, DIV. busy=1 exactly when state != IDLE (registered, not derived from start).
- Hazard unit stalls md instructions on (start | busy); the unit does not rely on that for safety.
- IDLE, start=1, cancel=0:
  - Latch A, B, signmd.
  - Go to MULT (mord=0) or DIV (mord=1); counter <= N-1, with N = MULT_CYCLES or DIV_CYCLES.
- MULT/DIV: counter decrements each cycle. On the edge where counter==0, commit the result to HI/LO and return to IDLE.
- Latency: start sampled at edge E0. busy is high for exactly N cycles after E0. New HI/LO are visible on rdata the first cycle busy is low.
- Multiply: 2*WIDTH-bit product; HI=upper WIDTH, LO=lower WIDTH. signmd selects signed or unsigned.
- Divide: LO=quotient, HI=remainder.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed overflow (most-negative / -1): LO=most-negative, HI=0.
  - Divisor 0: HI and LO unchanged; the op still occupies N busy cycles.
- weMD in IDLE, cancel=0: on the edge, write A to HI (wHiLo=0) or LO (wHiLo=1).
- start and weMD asserted together in IDLE: start wins, weMD dropped.
- start or weMD while busy: ignored; the in-flight op continues.
- cancel=1 while busy: next edge state=IDLE, busy=0, HI/LO keep their pre-op values. Cancel on the commit edge also suppresses the commit.
- cancel=1 in IDLE: same-cycle start and weMD are dropped.
- rdata: combinational from current HI/LO per rHiLo. Reads during busy return the old values.
- Operands are latched at start, so changes on A/B after start have no effect.

Decomposition:
- Shared include constants.v holds:
  - state encodings: MD_IDLE, MD_MULT, MD_DIV;
  - select encodings: MD_SEL_HI=0, MD_SEL_LO=1;
  - op encoding: MD_OP_MUL=0, MD_OP_DIV=1.
- One sub-module, md_arith: purely combinational. Inputs are latched A, B, signmd and op. Outputs are hi_res, lo_res and div0.
- md_unit_pipe holds the FSM, counter, operand latches and HI/LO registers.
- Counter width is $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).

Test Plan:
- Signed mult: start, mord=0, signmd=1, A=0xFFFFFFFE (-2), B=3 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Unsigned multu: A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE.
- Signed div: A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Signed div overflow: A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: HI=0x11, LO=0x22 preset via mthi/mtlo, then divu A=5, B=0 -> busy 10 cycles, HI=0x11, LO=0x22.
- Cancel and reset:
  - Preset LO=0x22, start mult 3*4, assert cancel at busy cycle 3 -> busy=0 next cycle, LO stays 0x22.
  - Start+cancel same cycle -> busy never rises.
  - Async reset at busy cycle 2 -> busy, HI, LO all 0 immediately.
  - weMD (wHiLo=1, A=0x55) during busy -> ignored, LO=0x0C after the mult.

Source files
------------

// File: rtl/md_unit_pipe_pkg.sv
// ============================================================================
// md_unit_pipe_pkg : shared encodings for the multi-cycle multiply/divide unit
// Revision: 1.0
// ============================================================================
`default_nettype none

package md_unit_pipe_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2
    } md_state_t;

    localparam logic MD_SEL_HI = 1'b0;
    localparam logic MD_SEL_LO = 1'b1;
    localparam logic MD_OP_MUL = 1'b0;
    localparam logic MD_OP_DIV = 1'b1;

    function automatic int md_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/md_unit_pipe_arith.sv
// ============================================================================
// md_arith : combinational multiply / divide datapath on latched operands
// Revision: 1.0
// ============================================================================
`default_nettype none

module md_arith
    import md_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signmd,
    input  logic             op,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res,
    output logic             div0
);

    logic             a_neg;
    logic             b_neg;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] b_safe;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;

    always_comb begin
        a_neg  = signmd & a[WIDTH-1];
        b_neg  = signmd & b[WIDTH-1];
        // The low 2*WIDTH bits of the extended product are correct for both signednesses.
        a_ext  = {{WIDTH{a_neg}}, a};
        b_ext  = {{WIDTH{b_neg}}, b};
        prod   = a_ext * b_ext;

        a_mag  = a_neg ? (~a + 1'b1) : a;
        b_mag  = b_neg ? (~b + 1'b1) : b;
        div0   = (op == MD_OP_DIV) && (b == '0);
        b_safe = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;

        if (op == MD_OP_MUL) begin
            hi_res = prod[2*WIDTH-1:WIDTH];
            lo_res = prod[WIDTH-1:0];
        end else begin
            // Most-negative / -1 yields magnitude 2^(WIDTH-1), which wraps to most-negative.
            lo_res = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
            hi_res = a_neg ? (~r_mag + 1'b1) : r_mag;
        end
    end

endmodule

`default_nettype wire

// File: rtl/md_unit_pipe.sv
// ============================================================================
// md_unit_pipe : multi-cycle multiply/divide unit with HI/LO and flush cancel
// Revision: 1.0
// ============================================================================
`default_nettype none

module md_unit_pipe
    import md_unit_pipe_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mord,
    input  logic             signmd,
    input  logic             weMD,
    input  logic             wHiLo,
    input  logic             rHiLo,
    input  logic             cancel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] rdata
);

    localparam int CNT_W = $clog2(md_max(MULT_CYCLES, DIV_CYCLES) + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_t        state;
    md_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sign_q;
    logic             op_q;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi_res;
    logic [WIDTH-1:0] lo_res;
    logic             div0;
    logic             load_ops;
    logic             commit;
    logic             mt_we;

    md_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .a      (a_q),
        .b      (b_q),
        .signmd (sign_q),
        .op     (op_q),
        .hi_res (hi_res),
        .lo_res (lo_res),
        .div0   (div0)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_ops  = 1'b0;
        commit    = 1'b0;
        mt_we     = 1'b0;
        case (state)
            MD_IDLE: begin
                if (!cancel) begin
                    if (start) begin
                        load_ops  = 1'b1;
                        state_nxt = (mord == MD_OP_DIV) ? MD_DIV : MD_MULT;
                        cnt_nxt   = (mord == MD_OP_DIV) ? DIV_LOAD : MULT_LOAD;
                    end else if (weMD) begin
                        mt_we = 1'b1;
                    end
                end
            end
            MD_MULT, MD_DIV: begin
                if (cancel) begin
                    state_nxt = MD_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    // A zero divisor still burns its cycles but leaves HI/LO untouched.
                    commit    = !div0;
                    state_nxt = MD_IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = MD_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            sign_q <= 1'b0;
            op_q   <= MD_OP_MUL;
        end else if (load_ops) begin
            a_q    <= A;
            b_q    <= B;
            sign_q <= signmd;
            op_q   <= mord;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            hi <= hi_res;
            lo <= lo_res;
        end else if (mt_we) begin
            if (wHiLo == MD_SEL_LO) begin
                lo <= A;
            end else begin
                hi <= A;
            end
        end
    end

    assign busy  = (state != MD_IDLE);
    assign rdata = (rHiLo == MD_SEL_LO) ? lo : hi;

endmodule

`default_nettype wire

// File: tb/tb_md_unit_pipe.sv
// ============================================================================
// tb_md_unit_pipe : scoreboard bench for md_unit_pipe
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_md_unit_pipe;

    localparam int WIDTH       = 32;
    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, mord, signmd, weMD, wHiLo, rHiLo, cancel;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] rdata;

    exp_t        sb_q[$];
    logic [31:0] mdl_hi, mdl_lo;
    int          n_cmp = 0;
    int          n_err = 0;

    md_unit_pipe #(
        .WIDTH       (WIDTH),
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mord   (mord),
        .signmd (signmd),
        .weMD   (weMD),
        .wHiLo  (wHiLo),
        .rHiLo  (rHiLo),
        .cancel (cancel),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .rdata  (rdata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_hl(output logic [31:0] rh, output logic [31:0] rl);
        rHiLo = 1'b0;
        #1 rh = rdata;
        rHiLo = 1'b1;
        #1 rl = rdata;
    endtask

    task automatic model_op(input logic mo, input logic sg, input logic [31:0] a,
                            input logic [31:0] b, output logic [31:0] eh, output logic [31:0] el);
        longint      sa, sb, sp;
        logic [63:0] up;
        int          ia, ib;
        eh = mdl_hi;
        el = mdl_lo;
        if (!mo) begin
            if (sg) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                sp = sa * sb;
                up = sp;
            end else begin
                up = 64'(a) * 64'(b);
            end
            eh = up[63:32];
            el = up[31:0];
        end else if (b != 32'd0) begin
            if (sg) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    el = 32'h8000_0000;
                    eh = 32'd0;
                end else begin
                    ia = $signed(a);
                    ib = $signed(b);
                    el = ia / ib;
                    eh = ia % ib;
                end
            end else begin
                el = a / b;
                eh = a % b;
            end
        end
    endtask

    task automatic mt_write(input logic sel, input logic [31:0] val);
        @(negedge clk);
        weMD = 1'b1; wHiLo = sel; A = val;
        @(negedge clk);
        weMD = 1'b0;
        if (sel) mdl_lo = val; else mdl_hi = val;
    endtask

    // poke: weMD to LO mid-op; with_mt: weMD to HI in the same cycle as start
    task automatic run_op(input string tag, input logic mo, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input bit poke, input bit with_mt);
        exp_t        e;
        logic [31:0] rh, rl;
        int          n, cyc;
        n = mo ? DIV_CYCLES : MULT_CYCLES;
        @(negedge clk);
        start = 1'b1; mord = mo; signmd = sg; A = a; B = b;
        if (with_mt) begin weMD = 1'b1; wHiLo = 1'b0; end
        model_op(mo, sg, a, b, e.hi, e.lo);
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0; weMD = 1'b0; A = $urandom; B = $urandom; signmd = ~sg; mord = ~mo;
        cyc = 0;
        while (busy === 1'b1 && cyc < n + 4) begin
            cyc++;
            if (cyc == 1) begin
                read_hl(rh, rl);
                check_val({tag, " old-lo"}, rl, mdl_lo);
            end
            if (poke && cyc == 2) begin weMD = 1'b1; wHiLo = 1'b1; A = 32'h55; end
            if (poke && cyc == 3) weMD = 1'b0;
            @(negedge clk);
        end
        weMD = 1'b0;
        check_val({tag, " busy-cycles"}, 32'(cyc), 32'(n));
        read_hl(rh, rl);
        if (sb_q.size() == 0) begin
            check_val({tag, " sb-empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_val({tag, " hi"}, rh, e.hi);
            check_val({tag, " lo"}, rl, e.lo);
            mdl_hi = e.hi;
            mdl_lo = e.lo;
        end
    endtask

    task automatic cancel_op(input int at_cyc);
        logic [31:0] rh, rl;
        @(negedge clk);
        start = 1'b1; mord = 1'b0; signmd = 1'b0; A = 32'd3; B = 32'd4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < at_cyc; i++) @(negedge clk);
        check_val("cancel busy-before", 32'(busy), 32'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check_val("cancel busy-after", 32'(busy), 32'd0);
        read_hl(rh, rl);
        check_val("cancel hi", rh, mdl_hi);
        check_val("cancel lo", rl, mdl_lo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rh, rl;
        reset = 1'b1; start = 1'b0; mord = 1'b0; signmd = 1'b0; weMD = 1'b0;
        wHiLo = 1'b0; rHiLo = 1'b0; cancel = 1'b0; A = '0; B = '0;
        mdl_hi = '0; mdl_lo = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("reset busy", 32'(busy), 32'd0);
        read_hl(rh, rl);
        check_val("reset hi", rh, 32'd0);
        check_val("reset lo", rl, 32'd0);

        run_op("mult", 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        run_op("multu", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        run_op("div", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_op("div-ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);

        mt_write(1'b0, 32'h11);
        mt_write(1'b1, 32'h22);
        read_hl(rh, rl);
        check_val("mthi", rh, 32'h11);
        check_val("mtlo", rl, 32'h22);
        run_op("divu-0", 1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0);
        run_op("start+mt", 1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b1);

        cancel_op(3);
        cancel_op(MULT_CYCLES);

        // start and weMD both dropped when cancel is asserted in IDLE
        @(negedge clk);
        start = 1'b1; weMD = 1'b1; wHiLo = 1'b0; cancel = 1'b1; A = 32'h99; B = 32'd7;
        @(negedge clk);
        start = 1'b0; weMD = 1'b0; cancel = 1'b0;
        check_val("start+cancel busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_val("start+cancel busy2", 32'(busy), 32'd0);
        read_hl(rh, rl);
        check_val("start+cancel hi", rh, mdl_hi);

        run_op("poke", 1'b0, 1'b0, 32'd3, 32'd4, 1'b1, 1'b0);
        check_val("poke lo", mdl_lo, 32'h0C);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra, rb;
            logic        rm, rs;
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : ((i % 2) ? $urandom_range(1, 300) : $urandom);
            rm = i[0];
            rs = i[1];
            run_op("rand", rm, rs, ra, rb, 1'b0, 1'b0);
        end

        // async reset in the middle of an op
        @(negedge clk);
        start = 1'b1; mord = 1'b1; signmd = 1'b0; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check_val("areset busy", 32'(busy), 32'd0);
        read_hl(rh, rl);
        check_val("areset hi", rh, 32'd0);
        check_val("areset lo", rl, 32'd0);
        reset = 1'b0;
        mdl_hi = '0; mdl_lo = '0;
        repeat (DIV_CYCLES + 2) @(negedge clk);
        check_val("areset no-commit busy", 32'(busy), 32'd0);
        read_hl(rh, rl);
        check_val("areset no-commit lo", rl, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
